nested_if_operand_collector: RTL and testbench
==============================================

// Module: nested_if_operand_collector
// PURPOSE
//  - Upstream stage of the nested-if datapath. Deserialises a nibble stream into one operand frame {a,b,c,d,e,f}.
//  - Accepts beats over a valid/ready handshake and holds each completed frame on registered outputs until it is consumed.
//  - The frame drives the combinational nested-if evaluator directly: out_a..out_f map to its a..f.
// PARAMETERS
//  - NIB_W    default 4  width of one operand/beat
//  - NUM_OPS  default 6  beats per frame (a..f); fixed at 6 for the nested-if consumer
//  - CNT_W    default 8  width of frame counter
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        beat valid
//  in_ready   out  1        beat accepted when in_valid & in_ready
//  in_sof     in   1        beat is operand a (start of frame)
//  in_data    in   NIB_W    beat payload
//  in_par     in   1        even parity of in_data (port present only with NIF_COLLECT_PARITY_EN)
//  out_valid  out  1        frame valid
//  out_ready  in   1        consumer takes frame
//  out_a..out_f out NIB_W   operands a..f, registered
//  frame_cnt  out  CNT_W    frames delivered, wraps 2^CNT_W-1 -> 0
//  drop       out  1        one-cycle pulse: beat or partial frame discarded
// BEHAVIOUR
//  - Reset: state=IDLE, idx=0, in_ready=0, out_valid=0, out_a..f=0, frame_cnt=0, drop=0.
//  - in_ready is registered: 1 in IDLE/COLLECT, 0 in HOLD. No comb path out_ready->in_ready.
//  - FSM IDLE:
//    - accepted beat with in_sof -> store to slot a, idx=1, -> COLLECT.
//    - accepted beat without in_sof -> discarded, drop=1, stay IDLE.
//  - FSM COLLECT:
//    - accepted beat without in_sof -> store to slot idx, idx++.
//    - on the 6th beat (idx==5) -> copy slots to out_*, out_valid=1, -> HOLD.
//    - accepted beat with in_sof -> partial frame discarded, drop=1, beat restarts the frame as slot a, idx=1.
//  - FSM HOLD:
//    - out_* stable while out_valid=1.
//    - out_valid & out_ready -> out_valid=0, frame_cnt++, -> IDLE (in_ready=1 from next cycle).
//  - Latency: 6th beat accepted at edge N -> out_valid=1 after edge N. Max throughput one frame per 7 cycles.
//  - No arithmetic on payload; frame_cnt modulo 2^CNT_W.
//  - Async reset mid-frame: partial frame and held frame lost, no drop pulse.
//  - in_valid ignored when in_ready=0; in_data is don't-care then.
// CONFIGURATION
//  - NIF_COLLECT_PARITY_EN defined:
//    - in_par port exists.
//    - accepted beat with ^in_data != in_par -> drop=1, frame aborted, -> IDLE, beat not stored.
//  - Undefined: no in_par port, no parity check, behaviour as above.
// STRUCTURE
//  - Package nif_pkg:
//    - typedef enum logic[1:0] {NIF_IDLE, NIF_COLLECT, NIF_HOLD} nif_state_t
//    - localparam NIF_NUM_OPS=6
//    - typedef struct packed {logic[3:0] a,b,c,d,e,f;} nif_frame_t
//  - One sub-module nif_slot_buf: indexed write, parallel read of six nibble slots.
//    - FSM, counters and handshake stay in the top.
// TESTING
//  1 Reset 0 -> 1, idle 5 cycles -> in_ready=1, out_valid=0, frame_cnt=0, all out_*=0.
//  2 Beats 3(sof),7,8,9,4,2, out_ready=1:
//    - out_valid 1 cycle after the 6th beat, out_a..f=3,7,8,9,4,2, frame_cnt=1.
//  3 Frame 1..6 with out_ready=0 for 10 cycles:
//    - in_ready=0 and out_* stable throughout; release -> frame_cnt increments once.
//  4 Beats 5(sof),6, then sof 1,2,3,4,5,6:
//    - drop pulse on the second sof; output frame = 1,2,3,4,5,6.
//  5 Beat without sof in IDLE -> drop=1, no state change; rst_n low after 3 beats -> no output, frame_cnt=0.
//  6 With NIF_COLLECT_PARITY_EN: 3rd beat in_data=4'b0001, in_par=0 -> drop=1, return IDLE, no out_valid.

Source files
------------

// File: rtl/nif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nif_pkg
//  Description : Shared types and constants for the nested-if operand
//                collector (FSM state encoding, operand count, frame layout).
//  Revision    : 1.0  initial release
// ============================================================================
package nif_pkg;

    localparam int NIF_NUM_OPS = 6;

    typedef enum logic [1:0] {
        NIF_IDLE    = 2'd0,
        NIF_COLLECT = 2'd1,
        NIF_HOLD    = 2'd2
    } nif_state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] e;
        logic [3:0] f;
    } nif_frame_t;

endpackage
`default_nettype wire

// File: rtl/nif_slot_buf.sv
`default_nettype none
// ============================================================================
//  Module      : nif_slot_buf
//  Description : Six-entry nibble slot buffer. Indexed single write, parallel
//                read. The read view includes the write in flight so the
//                final beat of a frame can be captured on the same edge.
//  Revision    : 1.0  initial release
// ============================================================================
module nif_slot_buf
    import nif_pkg::*;
#(
    parameter int NIB_W   = 4,
    parameter int NUM_OPS = NIF_NUM_OPS,
    parameter int IDX_W   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_en,
    input  logic [IDX_W-1:0]         i_wr_idx,
    input  logic [NIB_W-1:0]         i_wr_data,
    output logic [NUM_OPS*NIB_W-1:0] o_view
);

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_slot
        logic [NIB_W-1:0] r_slot;
        logic             w_hit;

        assign w_hit = i_wr_en && (i_wr_idx == IDX_W'(i));

        // Slot storage: written only when this slot is addressed.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_slot <= '0;
            end else if (w_hit) begin
                r_slot <= i_wr_data;
            end
        end

        assign o_view[i*NIB_W +: NIB_W] = w_hit ? i_wr_data : r_slot;
    end

endmodule
`default_nettype wire

// File: rtl/nested_if_operand_collector.sv
`default_nettype none
// ============================================================================
//  Module      : nested_if_operand_collector
//  Description : Deserialises a valid/ready nibble stream into one operand
//                frame {a..f} and holds it on registered outputs until taken.
//                Optional macro NIF_COLLECT_PARITY_EN adds the in_par port and
//                an even-parity check that aborts the frame on error.
//  Revision    : 1.0  initial release
// ============================================================================
module nested_if_operand_collector
    import nif_pkg::*;
#(
    parameter int NIB_W   = 4,
    parameter int NUM_OPS = NIF_NUM_OPS,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [NIB_W-1:0] in_data,
`ifdef NIF_COLLECT_PARITY_EN
    input  logic             in_par,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NIB_W-1:0] out_a,
    output logic [NIB_W-1:0] out_b,
    output logic [NIB_W-1:0] out_c,
    output logic [NIB_W-1:0] out_d,
    output logic [NIB_W-1:0] out_e,
    output logic [NIB_W-1:0] out_f,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             drop
);

    localparam int               c_IDX_W    = 3;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_OPS - 1);

    nif_state_t                r_state, w_state_nxt;
    logic [c_IDX_W-1:0]        r_idx, w_idx_nxt;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic                      r_drop, w_drop_nxt;
    logic [CNT_W-1:0]          r_frame_cnt;
    logic [NUM_OPS*NIB_W-1:0]  r_out;
    logic [NUM_OPS*NIB_W-1:0]  w_view;
    logic                      w_acc;
    logic                      w_par_err;
    logic                      w_wr_en;
    logic [c_IDX_W-1:0]        w_wr_idx;
    logic                      w_load;
    logic                      w_consume;

    assign w_acc = in_valid && r_in_ready;

`ifdef NIF_COLLECT_PARITY_EN
    assign w_par_err = ((^in_data) != in_par);
`else
    assign w_par_err = 1'b0;
`endif

    nif_slot_buf #(
        .NIB_W   (NIB_W),
        .NUM_OPS (NUM_OPS),
        .IDX_W   (c_IDX_W)
    ) u_slot_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (in_data),
        .o_view    (w_view)
    );

    // Next-state, slot write and pulse decode for the collect FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_idx;
        w_drop_nxt  = 1'b0;
        w_load      = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            NIF_IDLE: begin
                if (w_acc) begin
                    if (w_par_err || !in_sof) begin
                        w_drop_nxt = 1'b1;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_wr_idx    = '0;
                        w_idx_nxt   = c_IDX_W'(1);
                        w_state_nxt = NIF_COLLECT;
                    end
                end
            end
            NIF_COLLECT: begin
                if (w_acc) begin
                    if (w_par_err) begin
                        w_drop_nxt  = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = NIF_IDLE;
                    end else if (in_sof) begin
                        // New start of frame: abandon the partial one and restart.
                        w_drop_nxt = 1'b1;
                        w_wr_en    = 1'b1;
                        w_wr_idx   = '0;
                        w_idx_nxt  = c_IDX_W'(1);
                    end else begin
                        w_wr_en = 1'b1;
                        if (r_idx == c_LAST_IDX) begin
                            w_load      = 1'b1;
                            w_idx_nxt   = '0;
                            w_state_nxt = NIF_HOLD;
                        end else begin
                            w_idx_nxt = r_idx + c_IDX_W'(1);
                        end
                    end
                end
            end
            NIF_HOLD: begin
                if (r_out_valid && out_ready) begin
                    w_consume   = 1'b1;
                    w_state_nxt = NIF_IDLE;
                end
            end
            default: begin
                w_state_nxt = NIF_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // State, handshake, output frame and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= NIF_IDLE;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_drop      <= 1'b0;
            r_frame_cnt <= '0;
            r_out       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_in_ready <= (w_state_nxt != NIF_HOLD);
            r_drop     <= w_drop_nxt;
            if (w_load) begin
                r_out       <= w_view;
                r_out_valid <= 1'b1;
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
            if (w_consume) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign drop      = r_drop;
    assign frame_cnt = r_frame_cnt;
    assign out_a     = r_out[0*NIB_W +: NIB_W];
    assign out_b     = r_out[1*NIB_W +: NIB_W];
    assign out_c     = r_out[2*NIB_W +: NIB_W];
    assign out_d     = r_out[3*NIB_W +: NIB_W];
    assign out_e     = r_out[4*NIB_W +: NIB_W];
    assign out_f     = r_out[5*NIB_W +: NIB_W];

endmodule
`default_nettype wire

// File: tb/tb_nested_if_operand_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nested_if_operand_collector
//  Description : Directed self-checking bench for nested_if_operand_collector.
//                Inputs change and outputs are sampled on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nested_if_operand_collector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sof = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_par = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_a, out_b, out_c, out_d, out_e, out_f;
    logic [7:0] frame_cnt;
    logic       drop;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    nested_if_operand_collector #(
        .NIB_W   (4),
        .NUM_OPS (6),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_data   (in_data),
`ifdef NIF_COLLECT_PARITY_EN
        .in_par    (in_par),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_e     (out_e),
        .out_f     (out_f),
        .frame_cnt (frame_cnt),
        .drop      (drop)
    );

    function automatic logic [23:0] frame();
        return {out_a, out_b, out_c, out_d, out_e, out_f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One beat: wait for in_ready (bounded), present for one rising edge.
    task automatic beat(input logic sof, input logic [3:0] data, input logic par_err);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = data;
        in_par   = (^data) ^ par_err;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] f);
        for (int k = 0; k < 6; k++) beat(k == 0, f[23-4*k -: 4], 1'b0);
    endtask

    initial begin
        logic [23:0] snap;
        int          bad;

        // 1: reset and idle
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("idle_frame", 32'(frame()), 32'h0);
        chk("idle_drop", 32'(drop), 32'd0);

        // 2: basic frame, consumer ready
        out_ready = 1'b1;
        send_frame(24'h378942);
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_frame", 32'(frame()), 32'h378942);
        chk("t2_in_ready_hold", 32'(in_ready), 32'd0);
        chk("t2_drop", 32'(drop), 32'd0);
        @(negedge clk);
        chk("t2_consumed", 32'(out_valid), 32'd0);
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t2_in_ready_back", 32'(in_ready), 32'd1);

        // 3: back-pressure for 10 cycles, inputs toggling meanwhile
        out_ready = 1'b0;
        send_frame(24'h123456);
        chk("t3_out_valid", 32'(out_valid), 32'd1);
        snap = frame();
        chk("t3_frame", 32'(snap), 32'h123456);
        bad = 0;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 4'(k + 7);
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || frame() !== snap || frame_cnt !== 8'd1) bad++;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("t3_hold_stable", 32'(bad), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_cnt", 32'(frame_cnt), 32'd2);
        chk("t3_release_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t3_cnt_once", 32'(frame_cnt), 32'd2);

        // 4: restart on a second sof
        beat(1'b1, 4'h5, 1'b0);
        chk("t4_first_sof_drop", 32'(drop), 32'd0);
        beat(1'b0, 4'h6, 1'b0);
        beat(1'b1, 4'hA, 1'b0);
        chk("t4_restart_drop", 32'(drop), 32'd1);
        beat(1'b0, 4'hB, 1'b0);
        chk("t4_drop_pulse", 32'(drop), 32'd0);
        beat(1'b0, 4'hC, 1'b0);
        beat(1'b0, 4'hD, 1'b0);
        beat(1'b0, 4'hE, 1'b0);
        chk("t4_not_yet", 32'(out_valid), 32'd0);
        beat(1'b0, 4'hF, 1'b0);
        chk("t4_out_valid", 32'(out_valid), 32'd1);
        chk("t4_frame", 32'(frame()), 32'hABCDEF);
        @(negedge clk);
        chk("t4_frame_cnt", 32'(frame_cnt), 32'd3);

        // 5: stray beat in IDLE, then async reset mid-frame
        beat(1'b0, 4'h9, 1'b0);
        chk("t5_idle_drop", 32'(drop), 32'd1);
        chk("t5_idle_ready", 32'(in_ready), 32'd1);
        beat(1'b1, 4'h1, 1'b0);
        chk("t5_drop_clear", 32'(drop), 32'd0);
        beat(1'b0, 4'h2, 1'b0);
        beat(1'b0, 4'h3, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_cnt", 32'(frame_cnt), 32'd0);
        chk("t5_rst_frame", 32'(frame()), 32'h0);
        chk("t5_rst_drop", 32'(drop), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(24'h9ABC12);
        chk("t5_after_rst_frame", 32'(frame()), 32'h9ABC12);
        @(negedge clk);
        chk("t5_after_rst_cnt", 32'(frame_cnt), 32'd1);

        // frame counter wrap 255 -> 0
        for (int k = 0; k < 254; k++) begin
            send_frame(24'(k * 24'h010203));
            @(negedge clk);
        end
        chk("wrap_255", 32'(frame_cnt), 32'd255);
        send_frame(24'h654321);
        chk("wrap_frame", 32'(frame()), 32'h654321);
        @(negedge clk);
        chk("wrap_zero", 32'(frame_cnt), 32'd0);

`ifdef NIF_COLLECT_PARITY_EN
        // 6: parity error on the third beat aborts the frame
        beat(1'b1, 4'h1, 1'b0);
        beat(1'b0, 4'h2, 1'b0);
        beat(1'b0, 4'h1, 1'b1);
        chk("t6_par_drop", 32'(drop), 32'd1);
        beat(1'b0, 4'h4, 1'b0);
        chk("t6_back_idle", 32'(drop), 32'd1);
        repeat (3) @(negedge clk);
        chk("t6_no_valid", 32'(out_valid), 32'd0);
        chk("t6_cnt", 32'(frame_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
